// File: rtl/matraptor_row_drain.sv
// Merges NQ column-sorted PE queues into one column-ascending output row,
// summing entries with equal columns; triples leave over ready/valid.
// Ports:
//   clk, rst                   clock, async active-high reset
//   start_valid/ready/row      row-drain command, row stamped on outputs
//   q_empty, q_head_val/col    FWFT queue heads; q_pop one-hot pop
//   out_valid/ready/val/row/col/last  output triple stream
//   busy, row_done             activity flag, end-of-row pulse
module matraptor_row_drain #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int NQ     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [IDX_W-1:0]     start_row,
  input  logic [NQ-1:0]        q_empty,
  input  logic [NQ*DATA_W-1:0] q_head_val,
  input  logic [NQ*IDX_W-1:0]  q_head_col,
  output logic [NQ-1:0]        q_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_val,
  output logic [IDX_W-1:0]     out_row,
  output logic [IDX_W-1:0]     out_col,
  output logic                 out_last,
  output logic                 busy,
  output logic                 row_done
);

  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MERGE,
    S_FLUSH
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  row_q;
  logic [IDX_W-1:0]  acc_col_q;
  logic [DATA_W-1:0] acc_val_q;
  logic              acc_vld_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_val_q;
  logic [IDX_W-1:0]  out_row_q;
  logic [IDX_W-1:0]  out_col_q;

  logic              m_any;
  logic [QW-1:0]     m_idx;
  logic [IDX_W-1:0]  m_col;
  logic [DATA_W-1:0] m_val;
  logic              slot_free;
  logic              same_col;
  logic              do_pop;
  logic              done_d;

  // Minimum-column non-empty head; strict compare keeps the lowest index on ties.
  always_comb begin
    m_any = 1'b0;
    m_idx = '0;
    m_col = '0;
    m_val = '0;
    for (int q = 0; q < NQ; q++) begin
      if (!q_empty[q] &&
          (!m_any || q_head_col[q*IDX_W +: IDX_W] < m_col)) begin
        m_any = 1'b1;
        m_idx = QW'(q);
        m_col = q_head_col[q*IDX_W +: IDX_W];
        m_val = q_head_val[q*DATA_W +: DATA_W];
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign same_col  = acc_vld_q && (m_col == acc_col_q);

  // A new column can only be taken when the held accumulator can move out.
  assign do_pop = (state_q == S_MERGE) && m_any &&
                  (!acc_vld_q || same_col || slot_free);

  always_comb begin
    q_pop = '0;
    if (do_pop) q_pop = NQ'(1) << m_idx;
  end

  // Once the last triple is loaded the accumulator is empty; finish on
  // its handshake, or at once when the row produced nothing.
  assign done_d = (state_q == S_FLUSH) && !acc_vld_q &&
                  (!(out_valid_q && out_last_q) || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      acc_col_q   <= '0;
      acc_val_q   <= '0;
      acc_vld_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_val_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            row_q     <= start_row;
            acc_vld_q <= 1'b0;
            state_q   <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (!m_any) begin
            state_q <= S_FLUSH;
          end else if (do_pop) begin
            if (same_col) begin
              acc_val_q <= acc_val_q + m_val;
            end else begin
              if (acc_vld_q) begin
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_val_q   <= acc_val_q;
                out_row_q   <= row_q;
                out_col_q   <= acc_col_q;
              end
              acc_val_q <= m_val;
              acc_col_q <= m_col;
              acc_vld_q <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          if (acc_vld_q) begin
            if (slot_free) begin
              out_valid_q <= 1'b1;
              out_last_q  <= 1'b1;
              out_val_q   <= acc_val_q;
              out_row_q   <= row_q;
              out_col_q   <= acc_col_q;
              acc_vld_q   <= 1'b0;
            end
          end else if (done_d) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign row_done    = done_d;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_val     = out_val_q;
  assign out_row     = out_row_q;
  assign out_col     = out_col_q;

endmodule

// File: tb/tb_matraptor_row_drain.sv
// Directed and random row drains of matraptor_row_drain, checked against
// a sort-and-sum reference of the loaded queue contents.
module tb_matraptor_row_drain;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int NQ = 8;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [IW-1:0] col;
  } ent_t;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          last;
  } trip_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [IW-1:0]    start_row = '0;
  logic [NQ-1:0]    q_empty = '1;
  logic [NQ*DW-1:0] q_head_val = '0;
  logic [NQ*IW-1:0] q_head_col = '0;
  logic [NQ-1:0]    q_pop;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_val;
  logic [IW-1:0]    out_row;
  logic [IW-1:0]    out_col;
  logic             out_last;
  logic             busy;
  logic             row_done;

  matraptor_row_drain #(.DATA_W(DW), .IDX_W(IW), .NQ(NQ)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_row(start_row),
    .q_empty(q_empty), .q_head_val(q_head_val),
    .q_head_col(q_head_col), .q_pop(q_pop),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .row_done(row_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  ent_t  fq[NQ][$];
  ent_t  ld[NQ][$];
  trip_t exp_q[$];
  trip_t got_q[$];
  int    exp_pops[$];
  int    got_pops[$];

  int    acc_cyc, first_pop_cyc, first_out_cyc, done_cyc;
  int    done_cnt = 0;
  int    stall_pops;
  bit    prev_stall = 1'b0;
  trip_t prev_t;

  task automatic compare(input string tag,
                         input logic [95:0] obs,
                         input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FWFT queue bank: pop on the edge, new head visible after it.
  always @(posedge clk) begin
    for (int q = 0; q < NQ; q++) begin
      if (q_pop[q] && fq[q].size() > 0) void'(fq[q].pop_front());
      q_empty[q] <= (fq[q].size() == 0);
      q_head_val[q*DW +: DW] <= (fq[q].size() > 0) ? fq[q][0].val : '0;
      q_head_col[q*IW +: IW] <= (fq[q].size() > 0) ? fq[q][0].col : '0;
    end
  end

  always @(negedge clk) begin
    trip_t cur;
    cur = {out_val, out_row, out_col, out_last};
    if (!rst) begin
      if (|q_pop) begin
        compare("pop_onehot", 96'($onehot(q_pop)), 96'd1);
        for (int q = 0; q < NQ; q++) begin
          if (q_pop[q]) begin
            compare("pop_nonempty", 96'(fq[q].size() > 0), 96'd1);
            got_pops.push_back(q);
          end
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        if (out_valid && !out_ready) stall_pops++;
      end
      if (start_valid && start_ready) acc_cyc = cyc;
      if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
      if (prev_stall) begin
        compare("hold_valid", 96'(out_valid), 96'd1);
        compare("hold_data", 96'(cur), 96'(prev_t));
      end
      if (out_valid && out_ready) got_q.push_back(cur);
      if (row_done) begin
        done_cyc = cyc;
        done_cnt++;
        compare("done_at_last",
                96'((out_valid && out_last && out_ready) ||
                    exp_q.size() == 0), 96'd1);
      end
      prev_stall = out_valid && !out_ready;
      prev_t = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clr_ld();
    for (int q = 0; q < NQ; q++) ld[q].delete();
  endtask

  task automatic add(input int q, input logic [DW-1:0] v, input int c);
    ld[q].push_back({v, IW'(c)});
  endtask

  // Reference: sum per column, emit in ascending column order; pops follow
  // a global (column, queue) sort of every loaded entry.
  task automatic build_exp(input logic [IW-1:0] row);
    logic [DW-1:0] sums[int];
    int keys[$];
    int n, i;
    exp_q.delete();
    exp_pops.delete();
    for (int q = 0; q < NQ; q++) begin
      for (int k = 0; k < ld[q].size(); k++) begin
        int c;
        c = int'(ld[q][k].col);
        if (sums.exists(c)) sums[c] = sums[c] + ld[q][k].val;
        else sums[c] = ld[q][k].val;
        keys.push_back(c * NQ + q);
      end
    end
    keys.sort();
    foreach (keys[j]) exp_pops.push_back(keys[j] % NQ);
    n = sums.num();
    i = 0;
    foreach (sums[c]) begin
      exp_q.push_back({sums[c], row, IW'(c), (i == n - 1)});
      i++;
    end
  endtask

  task automatic run_row(input logic [IW-1:0] row, input int rmode);
    int n, d0;
    build_exp(row);
    got_q.delete();
    got_pops.delete();
    first_pop_cyc = -1;
    first_out_cyc = -1;
    stall_pops = 0;
    for (int q = 0; q < NQ; q++) fq[q] = ld[q];
    out_ready = 1'b1;
    @(posedge clk); #1;
    compare("start_ready_idle", 96'(start_ready), 96'd1);
    d0 = done_cnt;
    start_valid = 1'b1;
    start_row = row;
    @(posedge clk); #1;
    start_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      case (rmode)
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = !(n >= 3 && n < 13);
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b1;
    compare("row_timeout", 96'(done_cnt == d0), 96'd0);
    if (done_cnt == d0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    compare("done_once", 96'(done_cnt - d0), 96'd1);
    compare("n_out", 96'(got_q.size()), 96'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      compare("triple", 96'(got_q[i]), 96'(exp_q[i]));
    compare("n_pops", 96'(got_pops.size()), 96'(exp_pops.size()));
    for (int i = 0; i < got_pops.size() && i < exp_pops.size(); i++)
      compare("pop_order", 96'(got_pops[i]), 96'(exp_pops[i]));
    if (exp_q.size() > 0) begin
      compare("first_pop_lat", 96'(first_pop_cyc - acc_cyc), 96'd1);
      compare("first_out_lat", 96'(first_out_cyc - acc_cyc >= 2), 96'd1);
    end else begin
      compare("empty_done_lat", 96'(done_cyc - acc_cyc), 96'd2);
      compare("empty_no_out", 96'(first_out_cyc), 96'(-1));
    end
    compare("idle_after", 96'({start_ready, busy, out_valid}), 96'b100);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare("rst_outs",
            96'({out_valid, out_last, row_done, busy, q_pop}), 96'd0);
    compare("rst_data", 96'({out_val, out_row, out_col}), 96'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    compare("rst_start_ready", 96'(start_ready), 96'd1);

    clr_ld(); add(0, 5, 1); add(0, 7, 3);
    run_row(16'd4, 0);

    clr_ld(); add(0, 10, 2); add(3, -3, 2); add(1, 1, 5);
    run_row(16'd9, 0);
    compare("t3_pops", 96'(got_pops.size()), 96'd3);

    clr_ld(); add(2, 3, 0); add(2, 4, 6); add(5, 8, 0); add(5, 1, 4);
    run_row(16'd2, 1);

    clr_ld();
    add(0, 1, 1); add(0, 2, 5); add(0, 3, 9);
    add(1, 4, 2); add(1, 5, 6);
    add(2, 6, 3); add(2, 7, 7);
    add(3, 8, 4); add(3, 9, 8);
    run_row(16'd7, 2);
    compare("stall_pops", 96'(stall_pops <= 1), 96'd1);

    clr_ld();
    run_row(16'd1, 0);

    clr_ld(); add(0, 32'h7FFF_FFFF, 3); add(4, 1, 3);
    run_row(16'd0, 0);
    compare("wrap_val", 96'(got_q.size() > 0 ? got_q[0].val : '0),
            96'h8000_0000);

    // Abort a row with reset part-way through.
    clr_ld();
    for (int q = 0; q < 4; q++)
      for (int k = 0; k < 4; k++) add(q, q + k, k * 2 + q);
    build_exp(16'd3);
    for (int q = 0; q < NQ; q++) fq[q] = ld[q];
    @(posedge clk); #1;
    start_valid = 1'b1;
    start_row = 16'd3;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare("mid_rst_outs",
              96'({out_valid, out_last, row_done, busy, q_pop}), 96'd0);
      compare("mid_rst_data", 96'({out_val, out_row, out_col}), 96'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int q = 0; q < NQ; q++) fq[q].delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    compare("mid_rst_ready", 96'(start_ready), 96'd1);
    compare("mid_rst_nodone", 96'(done_cnt - d0), 96'd0);

    for (int r = 0; r < 20; r++) begin
      clr_ld();
      for (int q = 0; q < NQ; q++) begin
        int n, c;
        n = $urandom_range(0, 3);
        c = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) begin
          add(q, $urandom, c);
          c = c + $urandom_range(1, 3);
        end
      end
      run_row(IW'($urandom), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
